handle_alloc_sched: RTL and testbench
=====================================

# handle_alloc_sched

Allocation scheduler for the object-handle translation table. Arbitrates ALLOC/FREE requests from up to NUM_REQ clients, tracks which handle ids are in use, and sequences the resulting map-write and invalidate operations onto the table's op/address/data bus. Sits between software-facing requesters and the handle translation unit, which it drives as its only table master.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- HNDL_WIDTH, 5, handle id width; NUM_HANDLES = 2**HNDL_WIDTH
- ADDR_WIDTH, 64, system address width; MAP_WIDTH = ADDR_WIDTH-HNDL_WIDTH
- i_clock  in  1  system clock, all state on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_cmd  in  NUM_REQ  0 = ALLOC, 1 = FREE
- i_req_data  in  NUM_REQ*MAP_WIDTH  ALLOC: base address; FREE: handle id in low HNDL_WIDTH bits
- o_req_ready  out  NUM_REQ  one-hot grant, high one cycle
- o_rsp_valid  out  NUM_REQ  one-hot response pulse
- o_rsp_id  out  HNDL_WIDTH  allocated/freed id
- o_rsp_err  out  1  request rejected
- o_tbl_op  out  3  0 NOP, 2 WRITE
- o_tbl_address  out  ADDR_WIDTH  handle-op address
- o_tbl_data  out  ADDR_WIDTH  map value or 0
- o_free_count  out  HNDL_WIDTH+1  ids currently free
- o_stat_alloc, o_stat_free, o_stat_err  out  16 each  event counters

## Operation
- Id NUM_HANDLES-1 is reserved (handle-op window); never allocated. Usable ids: 0..NUM_HANDLES-2.
- State: in_use bitmap (NUM_HANDLES-1 bits), round-robin pointer, FSM {IDLE, ISSUE, RESP}, latched request (requester index, cmd, data, chosen id, err).
- IDLE: if any i_req_valid, grant first valid requester at or after pointer (wrapping); assert its o_req_ready; latch request; pointer <= granted+1 mod NUM_REQ; -> ISSUE. Otherwise stay.
- Decision at grant: ALLOC picks lowest-index clear bit; err if no free id or base == 0 (0 means invalidate on the table). FREE err if id reserved or bit not set.
- ISSUE: if !err, o_tbl_op = WRITE, o_tbl_address = {1'b1, HNDL_WIDTH ones, zero pad, id}, o_tbl_data = ALLOC ? zero-extended base : 0; set/clear in_use bit on this edge. If err, o_tbl_op = NOP, bitmap unchanged. -> RESP.
- RESP: o_rsp_valid[granted] = 1, o_rsp_id = id (0 on ALLOC-full error), o_rsp_err = err. -> IDLE.
- o_free_count = NUM_HANDLES-1 − popcount(in_use), registered, updated with bitmap.
- Requester must hold valid/cmd/data until ready; dropping valid before grant is legal (no effect).

## Timing
- Grant at cycle t, table WRITE at t+1, response at t+2; next grant earliest t+3. Throughput one op per 3 cycles.
- o_tbl_* are NOP/0 in every cycle except ISSUE with no error.
- Reset values: all outputs 0, o_free_count = NUM_HANDLES-1, pointer 0, FSM IDLE, bitmap clear, counters 0.
- Reset mid-operation: FSM to IDLE immediately, no table op or response completes; table contents are not scrubbed (software re-maps after reset).
- Simultaneous requests: only one grant per IDLE cycle; others wait, no starvation (each waits at most NUM_REQ-1 grants).
- ALLOC of last free id: succeeds, o_free_count reaches 0; next ALLOC errs.
- Counters saturate at 16'hFFFF.

## Configuration
- HANDLE_SCHED_STATS_EN defined: o_stat_alloc/o_stat_free count successful ALLOC/FREE in RESP; o_stat_err counts errored responses.
- Not defined: counter logic omitted, the three stat ports tied to 0; all other behaviour identical.

## Structure
- Shared package: ADDR_WIDTH, HNDL_WIDTH defaults, op encodings (NOP/READ/WRITE), ALLOC/FREE cmd encoding, FSM state enum, handle-op address construction function.
- One sub-module: handle_rr_arbiter (NUM_REQ-wide round-robin grant with pointer update on accept).

## Test plan
- Reset, single ALLOC base 0x10 from req0 -> ready t, WRITE addr 0x8000_0000_0000_0000|0x7C00_0000_0000_0000 (id 0) data 0x10 at t+1, rsp id 0 err 0 at t+2, free_count 30.
- Four simultaneous ALLOCs, pointer 0 -> grants req0,1,2,3 in order, ids 0,1,2,3.
- FREE id 2 after allocation -> WRITE data 0; next ALLOC returns id 2.
- FREE unallocated id 5, FREE id 31, ALLOC base 0 -> each err 1, tbl_op NOP, bitmap unchanged.
- Allocate 31 ids, 32nd ALLOC -> err 1, rsp id 0, free_count 0.
- Assert i_reset_n low during ISSUE -> no response pulse, outputs 0 asynchronously, free_count 31 after release.

Source files
------------

// File: rtl/handle_alloc_sched_pkg.sv
// Shared types and constants for the handle allocation scheduler.
// Holds the table op / command encodings, FSM states and the handle-op address builder.
package handle_alloc_sched_pkg;

    localparam int unsigned NumReqDefault    = 4;
    localparam int unsigned HndlWidthDefault = 5;
    localparam int unsigned AddrWidthDefault = 64;
    localparam int unsigned MaxAddrWidth     = 64;

    typedef enum logic [2:0] {
        TblNop   = 3'd0,
        TblRead  = 3'd1,
        TblWrite = 3'd2
    } tbl_op_e;

    typedef enum logic {
        CmdAlloc = 1'b0,
        CmdFree  = 1'b1
    } req_cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } sched_state_e;

    // {1, hndl_w ones, zero pad, id}: the reserved top id selects the handle-op window.
    function automatic logic [MaxAddrWidth-1:0] handle_op_addr(
        input int unsigned             addr_w,
        input int unsigned             hndl_w,
        input logic [MaxAddrWidth-1:0] id
    );
        logic [MaxAddrWidth-1:0] ones;
        ones = (MaxAddrWidth'(1) << hndl_w) - MaxAddrWidth'(1);
        return (MaxAddrWidth'(1) << (addr_w - 1)) | (ones << (addr_w - 1 - hndl_w)) | id;
    endfunction

endpackage

// File: rtl/handle_alloc_sched_if.sv
// Request/response and table-bus signals of the handle allocation scheduler.
// master: the scheduler itself; slave: requesters plus the translation table.
interface handle_alloc_sched_if
    import handle_alloc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NumReqDefault,
    parameter int unsigned HNDL_WIDTH = HndlWidthDefault,
    parameter int unsigned ADDR_WIDTH = AddrWidthDefault
);
    localparam int unsigned MAP_WIDTH = ADDR_WIDTH - HNDL_WIDTH;

    logic [NUM_REQ-1:0]           i_req_valid;
    logic [NUM_REQ-1:0]           i_req_cmd;
    logic [NUM_REQ*MAP_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]           o_req_ready;
    logic [NUM_REQ-1:0]           o_rsp_valid;
    logic [HNDL_WIDTH-1:0]        o_rsp_id;
    logic                         o_rsp_err;
    logic [2:0]                   o_tbl_op;
    logic [ADDR_WIDTH-1:0]        o_tbl_address;
    logic [ADDR_WIDTH-1:0]        o_tbl_data;

    modport master (
        input  i_req_valid, i_req_cmd, i_req_data,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_err,
        output o_tbl_op, o_tbl_address, o_tbl_data
    );

    modport slave (
        output i_req_valid, i_req_cmd, i_req_data,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_err,
        input  o_tbl_op, o_tbl_address, o_tbl_data
    );

endinterface

// File: rtl/handle_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
// The pointer moves to granted+1 only when the grant is accepted.
module handle_rr_arbiter #(
    parameter int unsigned NumReq = 4,
    localparam int unsigned IdxW  = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              accept_i,
    output logic              valid_o,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   gnt_idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    int unsigned     cand;

    always_comb begin
        valid_o   = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = (32'(ptr_q) + k) % NumReq;
            if (!valid_o && req_i[cand]) begin
                valid_o   = 1'b1;
                gnt_idx_o = IdxW'(cand);
            end
        end
        if (valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && valid_o) begin
            ptr_d = (gnt_idx_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/handle_alloc_sched.sv
// Handle allocation scheduler: arbitrates ALLOC/FREE, tracks the in-use bitmap and drives
// map writes onto the translation table. Define HANDLE_SCHED_STATS_EN for event counters.
module handle_alloc_sched
    import handle_alloc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NumReqDefault,
    parameter int unsigned HNDL_WIDTH = HndlWidthDefault,
    parameter int unsigned ADDR_WIDTH = AddrWidthDefault
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    handle_alloc_sched_if.master  sched_if,
    output logic [HNDL_WIDTH:0]   o_free_count,
    output logic [15:0]           o_stat_alloc,
    output logic [15:0]           o_stat_free,
    output logic [15:0]           o_stat_err
);

    localparam int unsigned MAP_WIDTH   = ADDR_WIDTH - HNDL_WIDTH;
    localparam int unsigned NUM_HANDLES = 1 << HNDL_WIDTH;
    localparam int unsigned NUM_IDS     = NUM_HANDLES - 1;
    localparam int unsigned IDX_W       = $clog2(NUM_REQ);
    localparam int unsigned CNT_W       = HNDL_WIDTH + 1;

    sched_state_e          state_q, state_d;
    logic [NUM_IDS-1:0]    in_use_q, in_use_d;
    logic [CNT_W-1:0]      free_count_q, free_count_d;
    logic [IDX_W-1:0]      req_idx_q, req_idx_d;
    logic                  cmd_q, cmd_d;
    logic [MAP_WIDTH-1:0]  data_q, data_d;
    logic [HNDL_WIDTH-1:0] id_q, id_d;
    logic                  err_q, err_d;

    logic                  arb_valid;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  sel_cmd;
    logic [MAP_WIDTH-1:0]  sel_data;
    logic [HNDL_WIDTH-1:0] sel_id;
    logic                  free_found;
    logic [HNDL_WIDTH-1:0] free_id;
    logic [NUM_HANDLES-1:0] in_use_ext;
    logic [CNT_W-1:0]      used_cnt;
    logic [MaxAddrWidth-1:0] op_addr;
    logic [NUM_REQ-1:0]    rsp_vec;

    handle_rr_arbiter #(
        .NumReq (NUM_REQ)
    ) u_arb (
        .clk_i     (i_clock),
        .rst_ni    (i_reset_n),
        .req_i     (sched_if.i_req_valid),
        .accept_i  (state_q == StIdle),
        .valid_o   (arb_valid),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    assign sel_cmd  = sched_if.i_req_cmd[arb_idx];
    assign sel_data = sched_if.i_req_data[32'(arb_idx)*MAP_WIDTH +: MAP_WIDTH];
    assign sel_id   = sel_data[HNDL_WIDTH-1:0];

    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (!in_use_q[i]) begin
                free_found = 1'b1;
                free_id    = HNDL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_idx_d  = req_idx_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        id_d       = id_q;
        err_d      = err_q;
        // The reserved id reads back as a permanently clear bit, so FREE of it errs.
        in_use_ext = {1'b0, in_use_q};
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    req_idx_d = arb_idx;
                    cmd_d     = sel_cmd;
                    data_d    = sel_data;
                    if (sel_cmd == CmdAlloc) begin
                        id_d  = free_found ? free_id : '0;
                        err_d = !free_found || (sel_data == '0);
                    end else begin
                        id_d  = sel_id;
                        err_d = (sel_id == HNDL_WIDTH'(NUM_IDS)) || !in_use_ext[sel_id];
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!err_q) begin
                    in_use_ext[id_q] = (cmd_q == CmdAlloc);
                end
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        in_use_d = in_use_ext[NUM_IDS-1:0];
    end

    always_comb begin
        used_cnt = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            used_cnt = used_cnt + CNT_W'(in_use_d[i]);
        end
        free_count_d = CNT_W'(NUM_IDS) - used_cnt;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            in_use_q     <= '0;
            free_count_q <= CNT_W'(NUM_IDS);
            req_idx_q    <= '0;
            cmd_q        <= 1'b0;
            data_q       <= '0;
            id_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_use_q     <= in_use_d;
            free_count_q <= free_count_d;
            req_idx_q    <= req_idx_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            id_q         <= id_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        op_addr = handle_op_addr(ADDR_WIDTH, HNDL_WIDTH, MaxAddrWidth'(id_q));
        rsp_vec = '0;
        rsp_vec[req_idx_q] = 1'b1;

        // Ready is gated by reset so every output reads 0 while reset is held.
        sched_if.o_req_ready   = (state_q == StIdle && i_reset_n) ? arb_gnt : '0;
        sched_if.o_rsp_valid   = (state_q == StResp) ? rsp_vec : '0;
        sched_if.o_rsp_id      = (state_q == StResp) ? id_q : '0;
        sched_if.o_rsp_err     = (state_q == StResp) && err_q;
        sched_if.o_tbl_op      = TblNop;
        sched_if.o_tbl_address = '0;
        sched_if.o_tbl_data    = '0;
        if (state_q == StIssue && !err_q) begin
            sched_if.o_tbl_op      = TblWrite;
            sched_if.o_tbl_address = op_addr[ADDR_WIDTH-1:0];
            sched_if.o_tbl_data    = (cmd_q == CmdAlloc) ? {{HNDL_WIDTH{1'b0}}, data_q} : '0;
        end
    end

    assign o_free_count = free_count_q;

`ifdef HANDLE_SCHED_STATS_EN
    logic [15:0] stat_alloc_q, stat_alloc_d;
    logic [15:0] stat_free_q, stat_free_d;
    logic [15:0] stat_err_q, stat_err_d;

    always_comb begin
        stat_alloc_d = stat_alloc_q;
        stat_free_d  = stat_free_q;
        stat_err_d   = stat_err_q;
        if (state_q == StResp) begin
            if (err_q) begin
                if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
            end else if (cmd_q == CmdAlloc) begin
                if (stat_alloc_q != 16'hFFFF) stat_alloc_d = stat_alloc_q + 16'd1;
            end else begin
                if (stat_free_q != 16'hFFFF) stat_free_d = stat_free_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stat_alloc_q <= '0;
            stat_free_q  <= '0;
            stat_err_q   <= '0;
        end else begin
            stat_alloc_q <= stat_alloc_d;
            stat_free_q  <= stat_free_d;
            stat_err_q   <= stat_err_d;
        end
    end

    assign o_stat_alloc = stat_alloc_q;
    assign o_stat_free  = stat_free_q;
    assign o_stat_err   = stat_err_q;
`else
    assign o_stat_alloc = '0;
    assign o_stat_free  = '0;
    assign o_stat_err   = '0;
`endif

endmodule

// File: tb/tb_handle_alloc_sched.sv
// Directed bench for handle_alloc_sched: a table of single-request transactions plus
// hand-written sequences for mid-operation reset, contention and table-full.
module tb_handle_alloc_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned HW = 5;
    localparam int unsigned AW = 64;
    localparam int unsigned MW = AW - HW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    handle_alloc_sched_if #(.NUM_REQ(NR), .HNDL_WIDTH(HW), .ADDR_WIDTH(AW)) bus ();

    logic [HW:0] free_count;
    logic [15:0] st_alloc, st_free, st_err;

    handle_alloc_sched #(
        .NUM_REQ    (NR),
        .HNDL_WIDTH (HW),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .sched_if     (bus),
        .o_free_count (free_count),
        .o_stat_alloc (st_alloc),
        .o_stat_free  (st_free),
        .o_stat_err   (st_err)
    );

    int checks = 0;
    int errors = 0;
    int exp_alloc = 0;
    int exp_free = 0;
    int exp_err = 0;

    typedef struct {
        int          idx;
        logic        cmd;
        logic [63:0] data;
        logic        exp_write;
        int          exp_id;
        logic        chk_id;
        logic        exp_err;
        int          exp_free;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_addr(input int id);
        return 64'hFC00_0000_0000_0000 | 64'(id);
    endfunction

    task automatic drive_req(input int idx, input logic cmd, input logic [63:0] data);
        bus.i_req_valid[idx]          = 1'b1;
        bus.i_req_cmd[idx]            = cmd;
        bus.i_req_data[idx*MW +: MW]  = data[MW-1:0];
    endtask

    // Called just after a rising edge with the scheduler idle; returns the same way.
    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] edata;
        drive_req(v.idx, v.cmd, v.data);
        @(negedge clk);
        check($sformatf("%s ready", tag), 64'(bus.o_req_ready), 64'(1) << v.idx);
        @(posedge clk);
        #1 bus.i_req_valid[v.idx] = 1'b0;
        @(negedge clk);
        edata = (v.exp_write && v.cmd == 1'b0) ? v.data : 64'd0;
        check($sformatf("%s tbl_op", tag), 64'(bus.o_tbl_op), v.exp_write ? 64'd2 : 64'd0);
        check($sformatf("%s tbl_addr", tag), bus.o_tbl_address,
              v.exp_write ? exp_addr(v.exp_id) : 64'd0);
        check($sformatf("%s tbl_data", tag), bus.o_tbl_data, edata);
        check($sformatf("%s early rsp", tag), 64'(bus.o_rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s rsp_valid", tag), 64'(bus.o_rsp_valid), 64'(1) << v.idx);
        if (v.chk_id) check($sformatf("%s rsp_id", tag), 64'(bus.o_rsp_id), 64'(v.exp_id));
        check($sformatf("%s rsp_err", tag), 64'(bus.o_rsp_err), 64'(v.exp_err));
        check($sformatf("%s free_count", tag), 64'(free_count), 64'(v.exp_free));
        check($sformatf("%s resp tbl_op", tag), 64'(bus.o_tbl_op), 64'd0);
        if (v.exp_err) exp_err++;
        else if (v.cmd == 1'b0) exp_alloc++;
        else exp_free++;
        @(posedge clk);
        #1;
    endtask

    int          gnt_who[$];
    int          gnt_cyc[$];
    int          rsp_who[$];
    int          rsp_id[$];
    logic [NR-1:0] gmask;
    vec_t        fv;

    initial begin
        //            idx cmd data    wr  id  chk err free
        vecs[0] = '{0, 1'b0, 64'h10, 1'b1, 0,  1'b1, 1'b0, 30};
        vecs[1] = '{1, 1'b0, 64'h20, 1'b1, 1,  1'b1, 1'b0, 29};
        vecs[2] = '{2, 1'b0, 64'h30, 1'b1, 2,  1'b1, 1'b0, 28};
        vecs[3] = '{3, 1'b1, 64'd2,  1'b1, 2,  1'b1, 1'b0, 29};
        vecs[4] = '{0, 1'b0, 64'h40, 1'b1, 2,  1'b1, 1'b0, 28};
        vecs[5] = '{1, 1'b1, 64'd5,  1'b0, 5,  1'b1, 1'b1, 28};
        vecs[6] = '{2, 1'b1, 64'd31, 1'b0, 31, 1'b1, 1'b1, 28};
        vecs[7] = '{3, 1'b0, 64'd0,  1'b0, 0,  1'b0, 1'b1, 28};
        vecs[8] = '{0, 1'b1, 64'd0,  1'b1, 0,  1'b1, 1'b0, 29};

        bus.i_req_valid = '0;
        bus.i_req_cmd   = '0;
        bus.i_req_data  = '0;

        // Reset state, with a request held to show ready stays low under reset.
        bus.i_req_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", 64'(bus.o_req_ready), 64'd0);
        check("reset rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("reset tbl_op", 64'(bus.o_tbl_op), 64'd0);
        check("reset tbl_addr", bus.o_tbl_address, 64'd0);
        check("reset free_count", 64'(free_count), 64'd31);
        check("reset stat_alloc", 64'(st_alloc), 64'd0);
        bus.i_req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted while a WRITE is on the table bus.
        drive_req(1, 1'b0, 64'h50);
        @(negedge clk);
        check("midrst ready", 64'(bus.o_req_ready), 64'd2);
        @(posedge clk);
        #1 bus.i_req_valid[1] = 1'b0;
        #2;
        check("midrst issue op", 64'(bus.o_tbl_op), 64'd2);
        rst_n = 1'b0;
        #1;
        check("midrst op", 64'(bus.o_tbl_op), 64'd0);
        check("midrst addr", bus.o_tbl_address, 64'd0);
        check("midrst data", bus.o_tbl_data, 64'd0);
        check("midrst free_count", 64'(free_count), 64'd31);
        repeat (2) begin
            @(negedge clk);
            check("midrst no rsp", 64'(bus.o_rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_alloc = 0;
        exp_free  = 0;
        exp_err   = 0;
        @(negedge clk);
        check("postrst rsp", 64'(bus.o_rsp_valid), 64'd0);
        check("postrst free_count", 64'(free_count), 64'd31);
        @(posedge clk);
        #1;

        // Four simultaneous ALLOCs from pointer 0.
        for (int i = 0; i < NR; i++) drive_req(i, 1'b0, 64'(i + 1) << 8);
        for (int c = 0; c < 20 && rsp_who.size() < 4; c++) begin
            @(negedge clk);
            gmask = bus.o_req_ready;
            for (int i = 0; i < NR; i++) begin
                if (gmask[i]) begin
                    gnt_who.push_back(i);
                    gnt_cyc.push_back(c);
                end
                if (bus.o_rsp_valid[i]) begin
                    rsp_who.push_back(i);
                    rsp_id.push_back(int'(bus.o_rsp_id));
                end
            end
            @(posedge clk);
            #1 bus.i_req_valid = bus.i_req_valid & ~gmask;
        end
        check("contend grants", 64'(gnt_who.size()), 64'd4);
        check("contend rsps", 64'(rsp_who.size()), 64'd4);
        for (int k = 0; k < gnt_who.size(); k++) begin
            check($sformatf("contend grant%0d", k), 64'(gnt_who[k]), 64'(k));
            if (k > 0) check($sformatf("contend gap%0d", k), 64'(gnt_cyc[k] - gnt_cyc[k-1]), 64'd3);
        end
        for (int k = 0; k < rsp_who.size(); k++) begin
            check($sformatf("contend rsp%0d who", k), 64'(rsp_who[k]), 64'(k));
            check($sformatf("contend rsp%0d id", k), 64'(rsp_id[k]), 64'(k));
        end
        bus.i_req_valid = '0;
        exp_alloc += 4;
        @(negedge clk);
        check("contend free_count", 64'(free_count), 64'd27);
        @(posedge clk);
        #1;

        // Fill the remaining ids, then one ALLOC too many.
        for (int k = 0; k < 27; k++) begin
            fv = '{0, 1'b0, 64'h1000 + 64'(k), 1'b1, 4 + k, 1'b1, 1'b0, 26 - k};
            run_vec(fv, $sformatf("fill%0d", k));
        end
        fv = '{1, 1'b0, 64'h2000, 1'b0, 0, 1'b1, 1'b1, 0};
        run_vec(fv, "full");

`ifdef HANDLE_SCHED_STATS_EN
        check("stat_alloc", 64'(st_alloc), 64'(exp_alloc));
        check("stat_free", 64'(st_free), 64'(exp_free));
        check("stat_err", 64'(st_err), 64'(exp_err));
`else
        check("stat_alloc tied", 64'(st_alloc), 64'd0);
        check("stat_free tied", 64'(st_free), 64'd0);
        check("stat_err tied", 64'(st_err), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
